rt_frame_serializer: RTL and testbench

Parametrised successor of the real-time word serializer feeding the PCIe host DMA FIFO.
- On each rising edge of the ATCA DMA tick it snapshots N_WORDS input words.
- It streams them, plus a trailer word, into the PCIe write FIFO with full-flag back-pressure.
- It detects and counts ticks that arrive while a frame is still in flight (overruns).
- It sits between the control/acquisition datapath and the PCIe DMA engine, in the processing_clock domain.

---
 rtl/rt_frame_serializer_pkg.sv | 15 +
 rtl/rt_frame_serializer_if.sv | 13 +
 rtl/rt_frame_serializer_tick_sync.sv | 25 ++
 rtl/rt_frame_serializer.sv | 177 +++++++++++++++++
 tb/tb_rt_frame_serializer.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rt_frame_serializer_pkg.sv
// Shared types and constants for the real-time frame serializer.
package rt_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        TRAIL = 2'd2,
        CHK   = 2'd3
    } state_t;

    localparam int unsigned DEF_N_WORDS = 42;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned CNT_W       = 16;

endpackage

// File: rtl/rt_frame_serializer_if.sv
// PCIe write-FIFO side of the serializer: write strobe, data, and full back-pressure.
interface rt_frame_serializer_if
    import rt_frame_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              PCIe_rd_en;
    logic [DATA_W-1:0] PCIe_rd_data;
    logic              fifo_full;

    modport master (output PCIe_rd_en, output PCIe_rd_data, input fifo_full);
    modport slave  (input PCIe_rd_en, input PCIe_rd_data, output fifo_full);
endinterface

// File: rtl/rt_frame_serializer_tick_sync.sv
// Three-flop synchroniser for the foreign-domain frame tick with rising-edge detect.
module rt_tick_sync
    import rt_frame_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/rt_frame_serializer.sv
// Snapshots N_WORDS words on each DMA tick and streams them plus a trailer into the PCIe FIFO.
// Optional trailing XOR checksum word when RT_FRAME_CHKSUM_EN is defined.
module rt_frame_serializer
    import rt_frame_pkg::*;
#(
    parameter int unsigned N_WORDS = DEF_N_WORDS,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned IDX_W   = 11
) (
    input  logic                      processing_clock,
    input  logic                      PCIe_trn_rst_n,
    input  logic                      ATCA_DMA_clk,
    input  logic                      enable,
    input  logic [N_WORDS*DATA_W-1:0] words_flat,
    rt_frame_serializer_if.master     fifo,
    output logic                      busy,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic [CNT_W-1:0]          overrun_cnt
);
    localparam int unsigned SEL_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  snap_q [N_WORDS];
    logic               load;
    logic               busy_q, busy_d;
    logic               rd_en_q, rd_en_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]   ovr_q, ovr_d;
    logic               rise;
    logic               start;
`ifdef RT_FRAME_CHKSUM_EN
    logic [DATA_W-1:0]  csum_q, csum_d;
`endif

    rt_tick_sync u_tick_sync (
        .clk_i   (processing_clock),
        .rst_ni  (PCIe_trn_rst_n),
        .async_i (ATCA_DMA_clk),
        .rise_o  (rise)
    );

    assign start = rise & enable;

    always_ff @(posedge processing_clock or negedge PCIe_trn_rst_n) begin
        if (!PCIe_trn_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = SEND;
            SEND:  if (!fifo.fifo_full && idx_q == LAST_IDX) state_d = TRAIL;
            TRAIL: if (!fifo.fifo_full) begin
`ifdef RT_FRAME_CHKSUM_EN
                state_d = CHK;
`else
                state_d = IDLE;
`endif
            end
`ifdef RT_FRAME_CHKSUM_EN
            CHK:   if (!fifo.fifo_full) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Idle cycles drive zero data; stalled cycles keep the last emitted word on the bus.
    always_comb begin
        idx_d     = idx_q;
        busy_d    = busy_q;
        rd_en_d   = 1'b0;
        rd_data_d = '0;
        frame_d   = frame_q;
        ovr_d     = ovr_q;
        load      = 1'b0;
`ifdef RT_FRAME_CHKSUM_EN
        csum_d    = csum_q;
`endif
        if (start && busy_q && ovr_q != '1) ovr_d = ovr_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load   = 1'b1;
                    idx_d  = '0;
                    busy_d = 1'b1;
`ifdef RT_FRAME_CHKSUM_EN
                    csum_d = '0;
`endif
                end
            end
            SEND: begin
                if (fifo.fifo_full) begin
                    rd_data_d = rd_data_q;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_data_d = snap_q[idx_q[SEL_W-1:0]];
                    idx_d     = idx_q + 1'b1;
`ifdef RT_FRAME_CHKSUM_EN
                    csum_d    = csum_q ^ snap_q[idx_q[SEL_W-1:0]];
`endif
                end
            end
            TRAIL: begin
                if (fifo.fifo_full) begin
                    rd_data_d = rd_data_q;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_data_d = snap_q[0];
`ifdef RT_FRAME_CHKSUM_EN
                    csum_d    = csum_q ^ snap_q[0];
`else
                    frame_d   = frame_q + 1'b1;
                    busy_d    = 1'b0;
`endif
                end
            end
`ifdef RT_FRAME_CHKSUM_EN
            CHK: begin
                if (fifo.fifo_full) begin
                    rd_data_d = rd_data_q;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_data_d = csum_q;
                    frame_d   = frame_q + 1'b1;
                    busy_d    = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge processing_clock or negedge PCIe_trn_rst_n) begin
        if (!PCIe_trn_rst_n) begin
            idx_q     <= '0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_data_q <= '0;
            frame_q   <= '0;
            ovr_q     <= '0;
`ifdef RT_FRAME_CHKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            rd_data_q <= rd_data_d;
            frame_q   <= frame_d;
            ovr_q     <= ovr_d;
`ifdef RT_FRAME_CHKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    always_ff @(posedge processing_clock or negedge PCIe_trn_rst_n) begin
        if (!PCIe_trn_rst_n) begin
            for (int unsigned i = 0; i < N_WORDS; i++) snap_q[i] <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < N_WORDS; i++) snap_q[i] <= words_flat[i*DATA_W +: DATA_W];
        end
    end

    assign fifo.PCIe_rd_en   = rd_en_q;
    assign fifo.PCIe_rd_data = rd_data_q;
    assign busy              = busy_q;
    assign frame_cnt         = frame_q;
    assign overrun_cnt       = ovr_q;
endmodule

// File: tb/tb_rt_frame_serializer.sv
// Self-checking bench for rt_frame_serializer; reference frames are built from the word list directly.
module tb_rt_frame_serializer;
    import rt_frame_pkg::*;

`ifdef RT_FRAME_CHKSUM_EN
    localparam int unsigned NW   = 4;
    localparam int unsigned FLEN = NW + 2;
`else
    localparam int unsigned NW   = 42;
    localparam int unsigned FLEN = NW + 1;
`endif
    localparam int unsigned DW     = 32;
    localparam int unsigned RST_AT = (NW > 12) ? 10 : 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0;
    logic              en = 1'b0;
    logic [NW*DW-1:0]  words_flat = '0;
    logic              busy;
    logic [15:0]       frame_cnt;
    logic [15:0]       overrun_cnt;

    int unsigned compared = 0;
    int unsigned mismatched = 0;
    int unsigned exp_frames = 0;
    int unsigned exp_ovr = 0;
    int unsigned cyc = 0;

    logic [DW-1:0] got_q[$];
    int unsigned   strobe_cyc[$];
    logic [DW-1:0] exp_q[$];

    rt_frame_serializer_if #(.DATA_W(DW)) fifo_if ();

    rt_frame_serializer #(.N_WORDS(NW), .DATA_W(DW), .IDX_W(11)) dut (
        .processing_clock (clk),
        .PCIe_trn_rst_n   (rst_n),
        .ATCA_DMA_clk     (tick),
        .enable           (en),
        .words_flat       (words_flat),
        .fifo             (fifo_if.master),
        .busy             (busy),
        .frame_cnt        (frame_cnt),
        .overrun_cnt      (overrun_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_if.PCIe_rd_en === 1'b1) begin
            got_q.push_back(fifo_if.PCIe_rd_data);
            strobe_cyc.push_back(cyc);
        end
    end

    // Expected frame: every word in order, word 0 again as the end marker, optional XOR of all emitted.
    function automatic void model_frame(input logic [NW*DW-1:0] w);
        logic [DW-1:0] x;
        x = '0;
        exp_q.delete();
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back(w[i*DW +: DW]);
            x = x ^ w[i*DW +: DW];
        end
        exp_q.push_back(w[DW-1:0]);
        x = x ^ w[DW-1:0];
`ifdef RT_FRAME_CHKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    function automatic logic [NW*DW-1:0] rand_words();
        logic [NW*DW-1:0] w;
        for (int i = 0; i < NW; i++) w[i*DW +: DW] = $urandom;
        return w;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        strobe_cyc.delete();
    endtask

    task automatic wait_frame(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned c = 0; c < budget; c++) begin
            step();
            if (got_q.size() >= FLEN && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        tick = 1'b0;
        fifo_if.fifo_full = 1'b0;
        step();
        step();
        compared++; if (fifo_if.PCIe_rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en got %0b want 0", fifo_if.PCIe_rd_en); end
        compared++; if (fifo_if.PCIe_rd_data !== '0) begin mismatched++; $display("FAIL reset_rd_data got %h want 0", fifo_if.PCIe_rd_data); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %0b want 0", busy); end
        compared++; if (frame_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        compared++; if (overrun_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_overrun_cnt got %0d want 0", overrun_cnt); end
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_basic();
        bit ok;
        for (int i = 0; i < NW; i++) words_flat[i*DW +: DW] = 32'h1000_0000 + i;
        model_frame(words_flat);
        clear_mon();
        tick = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            compared++;
            if (fifo_if.PCIe_rd_en !== 1'(e == 4)) begin
                mismatched++; $display("FAIL latency_edge_k+%0d rd_en got %0b want %0b", e - 1, fifo_if.PCIe_rd_en, e == 4);
            end
            if (e == 3) begin
                compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_at_snapshot got %0b want 1", busy); end
            end
        end
        tick = 1'b0;
        wait_frame(400, ok);
        exp_frames++;
        compared++; if (!ok) begin mismatched++; $display("FAIL basic_timeout got %0d strobes want %0d", got_q.size(), FLEN); end
        compared++; if (got_q.size() != FLEN) begin mismatched++; $display("FAIL basic_len got %0d want %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            compared++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL basic_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        compared++;
        if (got_q.size() == FLEN && strobe_cyc[FLEN-1] - strobe_cyc[0] != FLEN - 1) begin
            mismatched++; $display("FAIL basic_consecutive span got %0d want %0d", strobe_cyc[FLEN-1] - strobe_cyc[0], FLEN - 1);
        end
        compared++; if (frame_cnt !== 16'(exp_frames)) begin mismatched++; $display("FAIL basic_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
        compared++; if (fifo_if.PCIe_rd_data !== '0) begin mismatched++; $display("FAIL idle_data got %h want 0", fifo_if.PCIe_rd_data); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit reached;
        words_flat = rand_words();
        model_frame(words_flat);
        clear_mon();
        tick = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (c == 2) tick = 1'b0;
            if (got_q.size() == 4) begin reached = 1'b1; break; end
        end
        tick = 1'b0;
        compared++; if (!reached) begin mismatched++; $display("FAIL bp_start_timeout got %0d strobes want 4", got_q.size()); end
        fifo_if.fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            compared++;
            if (fifo_if.PCIe_rd_en !== 1'b0 || got_q.size() != 4 || fifo_if.PCIe_rd_data !== exp_q[3]) begin
                mismatched++; $display("FAIL bp_hold cyc%0d rd_en %0b data %h want rd_en 0 data %h", c, fifo_if.PCIe_rd_en, fifo_if.PCIe_rd_data, exp_q[3]);
            end
        end
        fifo_if.fifo_full = 1'b0;
        wait_frame(400, ok);
        exp_frames++;
        compared++; if (!ok || got_q.size() != FLEN) begin mismatched++; $display("FAIL bp_len got %0d want %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            compared++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL bp_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        compared++; if (frame_cnt !== 16'(exp_frames)) begin mismatched++; $display("FAIL bp_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_back_to_back();
        bit done;
        for (int f = 0; f < 4; f++) begin
            words_flat = rand_words();
            model_frame(words_flat);
            clear_mon();
            tick = 1'b1;
            done = 1'b0;
            for (int c = 0; c < 600; c++) begin
                fifo_if.fifo_full = (f % 2 == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
                step();
                if (c == 2) tick = 1'b0;
                if (fifo_if.PCIe_rd_en === 1'b0 && busy === 1'b1 && got_q.size() > 0) begin
                    compared++;
                    if (fifo_if.PCIe_rd_data !== got_q[$]) begin
                        mismatched++; $display("FAIL b2b_stall_data f%0d got %h want %h", f, fifo_if.PCIe_rd_data, got_q[$]);
                    end
                end
                if (got_q.size() >= FLEN && busy === 1'b0) begin done = 1'b1; break; end
            end
            tick = 1'b0;
            fifo_if.fifo_full = 1'b0;
            step();
            exp_frames++;
            compared++; if (!done || got_q.size() != FLEN) begin mismatched++; $display("FAIL b2b_len f%0d got %0d want %0d", f, got_q.size(), FLEN); end
            for (int i = 0; i < FLEN; i++) begin
                compared++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    mismatched++; $display("FAIL b2b_f%0d_word%0d got %h want %h", f, i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
                end
            end
            compared++; if (frame_cnt !== 16'(exp_frames)) begin mismatched++; $display("FAIL b2b_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        words_flat = rand_words();
        model_frame(words_flat);
        clear_mon();
        tick = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) tick = 1'b0;
            step();
        end
        tick = 1'b1;
        step(); step(); step();
        tick = 1'b0;
        wait_frame(400, ok);
        if (NW >= 20) exp_ovr++;
        else exp_frames++;
        exp_frames++;
        for (int c = 0; c < 10; c++) step();
        if (NW >= 20) begin
            compared++; if (overrun_cnt !== 16'(exp_ovr)) begin mismatched++; $display("FAIL overrun_cnt got %0d want %0d", overrun_cnt, exp_ovr); end
            compared++; if (got_q.size() != FLEN) begin mismatched++; $display("FAIL overrun_len got %0d want %0d", got_q.size(), FLEN); end
            for (int i = 0; i < FLEN; i++) begin
                compared++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    mismatched++; $display("FAIL overrun_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
                end
            end
        end
        compared++; if (frame_cnt !== 16'(exp_frames)) begin mismatched++; $display("FAIL overrun_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_enable();
        bit ok;
        clear_mon();
        en = 1'b0;
        tick = 1'b1;
        step(); step(); step();
        tick = 1'b0;
        for (int c = 0; c < 10; c++) step();
        compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL en_off_strobes got %0d want 0", got_q.size()); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL en_off_busy got %0b want 0", busy); end
        compared++; if (frame_cnt !== 16'(exp_frames) || overrun_cnt !== 16'(exp_ovr)) begin
            mismatched++; $display("FAIL en_off_counters got %0d/%0d want %0d/%0d", frame_cnt, overrun_cnt, exp_frames, exp_ovr);
        end
        en = 1'b1;
        words_flat = rand_words();
        model_frame(words_flat);
        clear_mon();
        tick = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) tick = 1'b0;
            step();
        end
        en = 1'b0;
        wait_frame(400, ok);
        exp_frames++;
        compared++; if (!ok || got_q.size() != FLEN) begin mismatched++; $display("FAIL en_mid_len got %0d want %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            compared++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL en_mid_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        compared++; if (frame_cnt !== 16'(exp_frames)) begin mismatched++; $display("FAIL en_mid_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
        en = 1'b1;
    endtask

    task automatic test_snapshot();
        bit ok;
        bit seen;
        words_flat = rand_words();
        model_frame(words_flat);
        clear_mon();
        tick = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (got_q.size() >= 1) begin seen = 1'b1; break; end
        end
        for (int i = 0; i < NW; i++) words_flat[i*DW +: DW] = 32'hDEAD_BEEF;
        step();
        tick = 1'b0;
        compared++; if (!seen) begin mismatched++; $display("FAIL snap_start_timeout got 0 strobes want 1"); end
        wait_frame(400, ok);
        exp_frames++;
        compared++; if (!ok || got_q.size() != FLEN) begin mismatched++; $display("FAIL snap_len got %0d want %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            compared++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL snap_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit reached;
        words_flat = rand_words();
        clear_mon();
        tick = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (c == 2) tick = 1'b0;
            if (got_q.size() >= RST_AT) begin reached = 1'b1; break; end
        end
        tick = 1'b0;
        compared++; if (!reached) begin mismatched++; $display("FAIL rstmid_start_timeout got %0d want %0d", got_q.size(), RST_AT); end
        rst_n = 1'b0;
        #1;
        exp_frames = 0;
        exp_ovr = 0;
        compared++; if (fifo_if.PCIe_rd_en !== 1'b0) begin mismatched++; $display("FAIL rstmid_rd_en got %0b want 0", fifo_if.PCIe_rd_en); end
        compared++; if (frame_cnt !== 16'd0 || overrun_cnt !== 16'd0) begin mismatched++; $display("FAIL rstmid_counters got %0d/%0d want 0/0", frame_cnt, overrun_cnt); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        step(); step();
        rst_n = 1'b1;
        step(); step();
        clear_mon();
        words_flat = rand_words();
        model_frame(words_flat);
        tick = 1'b1;
        step(); step(); step();
        tick = 1'b0;
        wait_frame(400, ok);
        exp_frames++;
        compared++; if (!ok || got_q.size() != FLEN) begin mismatched++; $display("FAIL rstmid_len got %0d want %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            compared++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL rstmid_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        compared++; if (frame_cnt !== 16'(exp_frames)) begin mismatched++; $display("FAIL rstmid_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_overrun_saturation();
        bit ok;
        bit reached;
        int unsigned n_rises;
        words_flat = rand_words();
        model_frame(words_flat);
        clear_mon();
        tick = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (got_q.size() >= 1) begin reached = 1'b1; break; end
        end
        fifo_if.fifo_full = 1'b1;
        compared++; if (!reached) begin mismatched++; $display("FAIL sat_start_timeout got 0 strobes want 1"); end
        n_rises = 0;
        for (int c = 0; c < 2 * 65540; c++) begin
            tick = ~tick;
            if (tick == 1'b1) n_rises++;
            step();
        end
        tick = 1'b0;
        step(); step(); step();
        exp_ovr = (exp_ovr + n_rises > 65535) ? 65535 : exp_ovr + n_rises;
        compared++; if (overrun_cnt !== 16'(exp_ovr)) begin mismatched++; $display("FAIL sat_overrun_cnt got %h want %h", overrun_cnt, exp_ovr); end
        compared++; if (busy !== 1'b1 || got_q.size() != 1) begin mismatched++; $display("FAIL sat_stalled busy %0b strobes %0d want 1/1", busy, got_q.size()); end
        fifo_if.fifo_full = 1'b0;
        wait_frame(400, ok);
        exp_frames++;
        compared++; if (!ok || got_q.size() != FLEN) begin mismatched++; $display("FAIL sat_len got %0d want %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            compared++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                mismatched++; $display("FAIL sat_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        compared++; if (overrun_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_overrun_hold got %h want ffff", overrun_cnt); end
        compared++; if (frame_cnt !== 16'(exp_frames)) begin mismatched++; $display("FAIL sat_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask

`ifdef RT_FRAME_CHKSUM_EN
    task automatic test_chksum();
        bit ok;
        logic [DW-1:0] want [6];
        want = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1, 32'hE};
        words_flat = {32'h8, 32'h4, 32'h2, 32'h1};
        clear_mon();
        tick = 1'b1;
        step(); step(); step();
        tick = 1'b0;
        wait_frame(100, ok);
        exp_frames++;
        compared++; if (!ok || got_q.size() != 6) begin mismatched++; $display("FAIL chk_len got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6; i++) begin
            compared++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin
                mismatched++; $display("FAIL chk_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, want[i]);
            end
        end
        compared++; if (frame_cnt !== 16'(exp_frames)) begin mismatched++; $display("FAIL chk_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask
`endif

    initial begin
        fifo_if.fifo_full = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_enable();
        test_snapshot();
`ifdef RT_FRAME_CHKSUM_EN
        test_chksum();
`endif
        test_reset_mid();
        test_overrun_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
